// File: rtl/rs_issue_scheduler_if.sv
// Issue-scheduler bus: RS ready/select/tag inputs, ALU/ACU handshakes, in-flight marks.
interface rs_issue_scheduler_if #(
  parameter int SIZE  = 15,
  parameter int TAG_W = 4,
  parameter int IDX_W = 4
);
  logic [SIZE-1:0]       ready;
  logic [SIZE-1:0]       acu_operation;
  logic [SIZE*TAG_W-1:0] entry_tag;
  logic [TAG_W-1:0]      rob_front;
  logic                  flush_valid;
  logic [SIZE-1:0]       clear;
  logic                  alu_ready;
  logic                  acu_ready;
  logic                  alu_valid;
  logic [IDX_W-1:0]      alu_idx;
  logic                  acu_valid;
  logic [IDX_W-1:0]      acu_idx;
  logic [SIZE-1:0]       in_flight;

  modport slave (
    input  ready, acu_operation, entry_tag, rob_front, flush_valid, clear,
           alu_ready, acu_ready,
    output alu_valid, alu_idx, acu_valid, acu_idx, in_flight
  );

  modport master (
    output ready, acu_operation, entry_tag, rob_front, flush_valid, clear,
           alu_ready, acu_ready,
    input  alu_valid, alu_idx, acu_valid, acu_idx, in_flight
  );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Oldest-first issue of ready RS entries to the ALU and ACU, one registered port per unit.
// Optional RS_ISSUE_STATS_EN adds saturating issue/stall counters.

module rs_issue_unit #(
  parameter int SIZE     = 15,
  parameter int ROB_SIZE = 15,
  parameter int TAG_W    = 4,
  parameter int IDX_W    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [SIZE-1:0]       cand_i,
  input  logic [SIZE*TAG_W-1:0] entry_tag_i,
  input  logic [TAG_W-1:0]      rob_front_i,
  input  logic                  flush_i,
  input  logic                  rdy_i,
  output logic                  valid_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic [SIZE-1:0]       cap_mask_o
);
  localparam int AW = TAG_W + 1;

  typedef enum logic {EMPTY, HOLD} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cap;

  logic [SIZE-1:0][AW-1:0] age;
  logic [SIZE-1:0][AW-1:0] sum;
  logic                    any;
  logic [IDX_W-1:0]        win;
  logic [AW-1:0]           best;

  // Age = distance from rob_front; a tag just below the front wraps to ROB_SIZE-1.
  for (genvar i = 0; i < SIZE; i++) begin : g_age
    assign sum[i] = {1'b0, entry_tag_i[i*TAG_W +: TAG_W]} + AW'(ROB_SIZE)
                  - {1'b0, rob_front_i};
    assign age[i] = (sum[i] >= AW'(ROB_SIZE)) ? sum[i] - AW'(ROB_SIZE) : sum[i];
  end

  // Ascending scan with strict compare keeps the lower index on equal age.
  always_comb begin
    any  = 1'b0;
    win  = '0;
    best = '1;
    for (int i = 0; i < SIZE; i++) begin
      if (cand_i[i] && (!any || age[i] < best)) begin
        any  = 1'b1;
        best = age[i];
        win  = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap     = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (any) begin
          cap     = 1'b1;
          idx_d   = win;
          state_d = HOLD;
        end
        HOLD: if (rdy_i) begin
          if (any) begin
            cap   = 1'b1;
            idx_d = win;
          end else begin
            state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign valid_o    = (state_q == HOLD);
  assign idx_o      = idx_q;
  assign cap_mask_o = cap ? (SIZE'(1) << idx_d) : '0;
endmodule

module rs_issue_scheduler #(
  parameter int SIZE     = 15,
  parameter int ROB_SIZE = 15,
  parameter int TAG_W    = 4,
  parameter int IDX_W    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
`ifdef RS_ISSUE_STATS_EN
  output logic [31:0]         alu_issue_cnt_o,
  output logic [31:0]         acu_issue_cnt_o,
  output logic [31:0]         stall_cnt_o,
`endif
  rs_issue_scheduler_if.slave bus
);
  localparam int NUM_UNITS = 2;  // 0 = ALU, 1 = ACU

  logic [NUM_UNITS-1:0][SIZE-1:0]  cand;
  logic [NUM_UNITS-1:0][SIZE-1:0]  cap_mask;
  logic [NUM_UNITS-1:0]            rdy;
  logic [NUM_UNITS-1:0]            vld;
  logic [NUM_UNITS-1:0][IDX_W-1:0] idx;
  logic [SIZE-1:0]                 in_flight_q, in_flight_d;

  // Disjoint candidate sets guarantee the two units never pick the same entry.
  assign cand[0] = bus.ready & ~in_flight_q & ~bus.acu_operation;
  assign cand[1] = bus.ready & ~in_flight_q &  bus.acu_operation;
  assign rdy     = {bus.acu_ready, bus.alu_ready};

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    rs_issue_unit #(
      .SIZE(SIZE), .ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W), .IDX_W(IDX_W)
    ) u_unit (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cand_i      (cand[u]),
      .entry_tag_i (bus.entry_tag),
      .rob_front_i (bus.rob_front),
      .flush_i     (bus.flush_valid),
      .rdy_i       (rdy[u]),
      .valid_o     (vld[u]),
      .idx_o       (idx[u]),
      .cap_mask_o  (cap_mask[u])
    );
  end

  // Capture is ORed in after clear so a same-edge capture keeps the mark set.
  always_comb begin
    in_flight_d = (in_flight_q & ~bus.clear) | cap_mask[0] | cap_mask[1];
    if (bus.flush_valid) in_flight_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) in_flight_q <= '0;
    else         in_flight_q <= in_flight_d;
  end

  assign bus.alu_valid = vld[0];
  assign bus.alu_idx   = idx[0];
  assign bus.acu_valid = vld[1];
  assign bus.acu_idx   = idx[1];
  assign bus.in_flight = in_flight_q;

`ifdef RS_ISSUE_STATS_EN
  logic [NUM_UNITS-1:0] fire;
  logic                 stall;
  logic [31:0]          alu_cnt_q, acu_cnt_q, stall_cnt_q;

  // A handshake coinciding with flush is dropped, so it is not counted.
  assign fire  = vld & rdy & {NUM_UNITS{~bus.flush_valid}};
  assign stall = |(vld & ~rdy);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_cnt_q   <= '0;
      acu_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fire[0] && alu_cnt_q   != '1) alu_cnt_q   <= alu_cnt_q + 32'd1;
      if (fire[1] && acu_cnt_q   != '1) acu_cnt_q   <= acu_cnt_q + 32'd1;
      if (stall   && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign alu_issue_cnt_o = alu_cnt_q;
  assign acu_issue_cnt_o = acu_cnt_q;
  assign stall_cnt_o     = stall_cnt_q;
`endif
endmodule
